// File: rtl/huffman_encoder_if.sv
// Symbol input and code-table output bundle of the Huffman table generator.
// The encoder takes the slave side; the producer and table consumer take the master side.
interface huffman_encoder_if #(
    parameter int BIT_WIDTH   = 2,
    parameter int NUM_SYMBOLS = 8
);
    logic [BIT_WIDTH:0]     data_in;
    logic                   data_enable;
    logic [BIT_WIDTH:0]     data_out_symbol;
    logic [3:0]             data_out_length;
    logic [NUM_SYMBOLS-2:0] data_out_code;
    logic                   data_out_state;

    modport master (
        output data_in, data_enable,
        input  data_out_symbol, data_out_length, data_out_code, data_out_state
    );

    modport slave (
        input  data_in, data_enable,
        output data_out_symbol, data_out_length, data_out_code, data_out_state
    );
endinterface

// File: rtl/huffman_encoder.sv
// Canonical Huffman table generator: counts a block of samples, merges groups into code lengths,
// assigns canonical codes, streams one entry per used symbol. Input is ignored while not collecting.
module huffman_encoder #(
    parameter int BIT_WIDTH   = 2,
    parameter int NUM_SYMBOLS = 8,
    parameter int NUM_SAMPLES = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    huffman_encoder_if.slave bus
);
    localparam int SW = BIT_WIDTH + 1;
    localparam int CW = NUM_SYMBOLS - 1;

    typedef enum logic [2:0] {S_COLLECT, S_INIT, S_MERGE, S_CODES, S_OUTPUT} state_t;

    state_t                 r_state, w_next_state;
    logic [7:0]             r_freq   [NUM_SYMBOLS];
    logic [7:0]             r_count;
    logic [SW-1:0]          r_grp    [NUM_SYMBOLS];
    logic [7:0]             r_weight [NUM_SYMBOLS];
    logic [NUM_SYMBOLS-1:0] r_alive;
    logic [3:0]             r_len    [NUM_SYMBOLS];
    logic [CW-1:0]          r_code   [NUM_SYMBOLS];
    logic [SW:0]            r_ptr;

    logic [SW-1:0]          r_out_sym;
    logic [3:0]             r_out_len;
    logic [CW-1:0]          r_out_code;
    logic                   r_out_vld;

    // Lightest live group, then the lightest of the rest; strict compare in id order breaks ties low.
    logic [SW-1:0] w_m1, w_m2, w_lo, w_hi;
    logic          w_found1, w_found2;
    logic [SW:0]   w_alive_cnt;

    always_comb begin
        w_m1        = '0;
        w_m2        = '0;
        w_found1    = 1'b0;
        w_found2    = 1'b0;
        w_alive_cnt = '0;
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (r_alive[i]) begin
                w_alive_cnt = w_alive_cnt + (SW+1)'(1);
                if (!w_found1 || r_weight[i] < r_weight[w_m1]) begin
                    w_m1     = SW'(i);
                    w_found1 = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (r_alive[i] && SW'(i) != w_m1) begin
                if (!w_found2 || r_weight[i] < r_weight[w_m2]) begin
                    w_m2     = SW'(i);
                    w_found2 = 1'b1;
                end
            end
        end
        w_lo = (w_m1 < w_m2) ? w_m1 : w_m2;
        w_hi = (w_m1 < w_m2) ? w_m2 : w_m1;
    end

    logic [3:0]    w_len_eff   [NUM_SYMBOLS];
    logic [CW-1:0] w_code      [NUM_SYMBOLS];
    logic [CW:0]   w_bl_count  [16];
    logic [CW:0]   w_next_code [16];

    // A lone symbol never merges, so it is promoted to length 1 here.
    always_comb begin
        for (int l = 0; l < 16; l++) begin
            w_bl_count[l]  = '0;
            w_next_code[l] = '0;
        end
        for (int s = 0; s < NUM_SYMBOLS; s++) begin
            w_code[s]    = '0;
            w_len_eff[s] = (r_freq[s] == 8'd0) ? 4'd0 :
                           (r_len[s] == 4'd0)  ? 4'd1 : r_len[s];
        end
        for (int s = 0; s < NUM_SYMBOLS; s++) begin
            if (w_len_eff[s] != 4'd0)
                w_bl_count[w_len_eff[s]] = w_bl_count[w_len_eff[s]] + (CW+1)'(1);
        end
        for (int l = 2; l < 16; l++)
            w_next_code[l] = (CW+1)'((w_next_code[l-1] + w_bl_count[l-1]) << 1);
        for (int s = 0; s < NUM_SYMBOLS; s++) begin
            if (w_len_eff[s] != 4'd0) begin
                w_code[s]                 = CW'(w_next_code[w_len_eff[s]]);
                w_next_code[w_len_eff[s]] = w_next_code[w_len_eff[s]] + (CW+1)'(1);
            end
        end
    end

    logic          w_sel_found;
    logic [SW-1:0] w_sel;

    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = '0;
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (!w_sel_found && (SW+1)'(i) >= r_ptr && r_freq[i] != 8'd0) begin
                w_sel       = SW'(i);
                w_sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_COLLECT;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: if (bus.data_enable && r_count == 8'(NUM_SAMPLES - 1)) w_next_state = S_INIT;
            S_INIT:    w_next_state = S_MERGE;
            S_MERGE:   if (w_alive_cnt <= (SW+1)'(1)) w_next_state = S_CODES;
            S_CODES:   w_next_state = S_OUTPUT;
            S_OUTPUT:  if (!w_sel_found) w_next_state = S_COLLECT;
            default:   w_next_state = S_COLLECT;
        endcase
    end

    logic          w_out_vld;
    logic [SW-1:0] w_out_sym;
    logic [3:0]    w_out_len;
    logic [CW-1:0] w_out_code;

    always_comb begin
        w_out_vld  = 1'b0;
        w_out_sym  = '0;
        w_out_len  = '0;
        w_out_code = '0;
        if (r_state == S_OUTPUT && w_sel_found) begin
            w_out_vld  = 1'b1;
            w_out_sym  = w_sel;
            w_out_len  = r_len[w_sel];
            w_out_code = r_code[w_sel];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vld  <= 1'b0;
            r_out_sym  <= '0;
            r_out_len  <= '0;
            r_out_code <= '0;
        end else begin
            r_out_vld  <= w_out_vld;
            r_out_sym  <= w_out_sym;
            r_out_len  <= w_out_len;
            r_out_code <= w_out_code;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_alive <= '0;
            r_ptr   <= '0;
            for (int s = 0; s < NUM_SYMBOLS; s++) begin
                r_freq[s]   <= '0;
                r_grp[s]    <= '0;
                r_weight[s] <= '0;
                r_len[s]    <= '0;
                r_code[s]   <= '0;
            end
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (bus.data_enable) begin
                        r_freq[bus.data_in] <= r_freq[bus.data_in] + 8'd1;
                        r_count             <= r_count + 8'd1;
                    end
                end
                S_INIT: begin
                    for (int s = 0; s < NUM_SYMBOLS; s++) begin
                        r_grp[s]    <= SW'(s);
                        r_weight[s] <= r_freq[s];
                        r_alive[s]  <= (r_freq[s] != 8'd0);
                        r_len[s]    <= '0;
                    end
                end
                S_MERGE: begin
                    if (w_alive_cnt > (SW+1)'(1)) begin
                        for (int s = 0; s < NUM_SYMBOLS; s++) begin
                            if (r_freq[s] != 8'd0 && (r_grp[s] == w_m1 || r_grp[s] == w_m2)) begin
                                r_len[s] <= r_len[s] + 4'd1;
                                r_grp[s] <= w_lo;
                            end
                        end
                        r_weight[w_lo] <= r_weight[w_m1] + r_weight[w_m2];
                        r_alive[w_hi]  <= 1'b0;
                    end
                end
                S_CODES: begin
                    r_ptr <= '0;
                    for (int s = 0; s < NUM_SYMBOLS; s++) begin
                        r_len[s]  <= w_len_eff[s];
                        r_code[s] <= w_code[s];
                    end
                end
                S_OUTPUT: begin
                    if (w_sel_found) begin
                        r_ptr <= {1'b0, w_sel} + (SW+1)'(1);
                    end else begin
                        r_count <= '0;
                        for (int s = 0; s < NUM_SYMBOLS; s++) r_freq[s] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out_symbol = r_out_sym;
    assign bus.data_out_length = r_out_len;
    assign bus.data_out_code   = r_out_code;
    assign bus.data_out_state  = r_out_vld;
endmodule

// File: tb/tb_huffman_encoder.sv
// Bench for huffman_encoder: directed blocks plus random blocks against a group-merge reference model.
module tb_huffman_encoder;
    localparam int BW    = 2;
    localparam int NS    = 8;
    localparam int NSAMP = 20;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    huffman_encoder_if #(.BIT_WIDTH(BW), .NUM_SYMBOLS(NS)) bus();

    huffman_encoder #(.BIT_WIDTH(BW), .NUM_SYMBOLS(NS), .NUM_SAMPLES(NSAMP)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    int m_freq [NS];
    int m_len  [NS];
    int m_code [NS];

    function automatic int key(input int w, input int id);
        return w * 16 + id;
    endfunction

    // Groups kept as (weight, id, member mask) lists; each step merges the two smallest keys.
    task automatic build_model();
        int gw[NS];
        int gid[NS];
        int gm[NS];
        int blc[16];
        int nc[16];
        int ng;
        int a;
        int b;
        ng = 0;
        for (int s = 0; s < NS; s++) begin
            m_len[s]  = 0;
            m_code[s] = 0;
            if (m_freq[s] > 0) begin
                gw[ng]  = m_freq[s];
                gid[ng] = s;
                gm[ng]  = 1 << s;
                ng++;
            end
        end
        if (ng == 1) m_len[gid[0]] = 1;
        while (ng > 1) begin
            a = 0;
            for (int i = 1; i < ng; i++)
                if (key(gw[i], gid[i]) < key(gw[a], gid[a])) a = i;
            b = (a == 0) ? 1 : 0;
            for (int i = 0; i < ng; i++)
                if (i != a && key(gw[i], gid[i]) < key(gw[b], gid[b])) b = i;
            for (int s = 0; s < NS; s++)
                if ((((gm[a] | gm[b]) >> s) & 1) == 1) m_len[s]++;
            gm[a]  = gm[a] | gm[b];
            gw[a]  = gw[a] + gw[b];
            gid[a] = (gid[a] < gid[b]) ? gid[a] : gid[b];
            gw[b]  = gw[ng-1];
            gid[b] = gid[ng-1];
            gm[b]  = gm[ng-1];
            ng--;
        end
        for (int l = 0; l < 16; l++) begin
            blc[l] = 0;
            nc[l]  = 0;
        end
        for (int s = 0; s < NS; s++) if (m_len[s] > 0) blc[m_len[s]]++;
        for (int l = 2; l < 16; l++) nc[l] = (nc[l-1] + blc[l-1]) << 1;
        for (int s = 0; s < NS; s++) begin
            if (m_len[s] > 0) begin
                m_code[s] = nc[m_len[s]];
                nc[m_len[s]]++;
            end
        end
    endtask

    task automatic model_from(input int syms[$]);
        for (int s = 0; s < NS; s++) m_freq[s] = 0;
        for (int i = 0; i < NSAMP && i < syms.size(); i++) m_freq[syms[i]]++;
        build_model();
    endtask

    task automatic send(input int syms[$], input bit gaps);
        foreach (syms[i]) begin
            @(negedge clock);
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.data_enable = 1'b0;
                    @(negedge clock);
                end
            end
            bus.data_in     = 3'(syms[i]);
            bus.data_enable = 1'b1;
        end
        @(negedge clock);
        bus.data_enable = 1'b0;
    endtask

    task automatic shuffle(inout int q[$]);
        int j;
        int t;
        for (int i = q.size() - 1; i > 0; i--) begin
            j    = int'($urandom_range(0, i));
            t    = q[i];
            q[i] = q[j];
            q[j] = t;
        end
    endtask

    task automatic collect_check(input string tag);
        int  obs_s[$];
        int  obs_l[$];
        int  obs_c[$];
        int  waited;
        bit  dirty;
        int  k;
        int  n_exp;
        int  kraft;
        bit  pf;
        waited = 0;
        dirty  = 1'b0;
        while (bus.data_out_state !== 1'b1 && waited < 200) begin
            if (bus.data_out_symbol != 0 || bus.data_out_length != 0 || bus.data_out_code != 0)
                dirty = 1'b1;
            @(negedge clock);
            waited++;
        end
        check({tag, "_started"}, int'(bus.data_out_state), 1);
        check({tag, "_build_zero"}, int'(dirty), 0);
        while (bus.data_out_state === 1'b1 && obs_s.size() < 16) begin
            obs_s.push_back(int'(bus.data_out_symbol));
            obs_l.push_back(int'(bus.data_out_length));
            obs_c.push_back(int'(bus.data_out_code));
            @(negedge clock);
        end
        check({tag, "_tail_zero"},
              int'({bus.data_out_state, bus.data_out_symbol, bus.data_out_length, bus.data_out_code}), 0);
        n_exp = 0;
        for (int s = 0; s < NS; s++) if (m_freq[s] > 0) n_exp++;
        check({tag, "_entries"}, obs_s.size(), n_exp);
        k = 0;
        for (int s = 0; s < NS; s++) begin
            if (m_freq[s] > 0 && k < obs_s.size()) begin
                check({tag, "_sym"},  obs_s[k], s);
                check({tag, "_len"},  obs_l[k], m_len[s]);
                check({tag, "_code"}, obs_c[k], m_code[s]);
                k++;
            end
        end
        if (obs_s.size() > 1) begin
            kraft = 0;
            pf    = 1'b1;
            for (int i = 0; i < obs_s.size(); i++) begin
                if (obs_l[i] >= 1 && obs_l[i] <= 7) kraft += 1 << (7 - obs_l[i]);
                else kraft += 1000;
                for (int j = 0; j < obs_s.size(); j++) begin
                    if (i != j && obs_l[i] <= obs_l[j] && obs_l[i] >= 1 && obs_l[j] <= 7 &&
                        (obs_c[j] >> (obs_l[j] - obs_l[i])) == obs_c[i])
                        pf = 1'b0;
                end
            end
            check({tag, "_kraft"}, kraft, 128);
            check({tag, "_prefix_free"}, int'(pf), 1);
        end
    endtask

    initial begin
        int q[$];
        int q2[$];
        int waited;
        int hi;
        bit stray;

        bus.data_in     = '0;
        bus.data_enable = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs",
              int'({bus.data_out_state, bus.data_out_symbol, bus.data_out_length, bus.data_out_code}), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // sym0 x10, sym1 x5, sym2 x3, sym3 x2
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(0);
        for (int i = 0; i < 5; i++)  q.push_back(1);
        for (int i = 0; i < 3; i++)  q.push_back(2);
        for (int i = 0; i < 2; i++)  q.push_back(3);
        shuffle(q);
        model_from(q);
        m_len[0] = 1; m_code[0] = 0;
        m_len[1] = 2; m_code[1] = 2;
        m_len[2] = 3; m_code[2] = 6;
        m_len[3] = 3; m_code[3] = 7;
        send(q, 1'b0);
        collect_check("skewed");

        q = {};
        for (int i = 0; i < NSAMP; i++) q.push_back(5);
        model_from(q);
        m_len[5] = 1; m_code[5] = 0;
        send(q, 1'b0);
        collect_check("single");

        q = {};
        for (int s = 0; s < 8; s += 2)
            for (int i = 0; i < 5; i++) q.push_back(s);
        shuffle(q);
        model_from(q);
        m_len[0] = 2; m_code[0] = 0;
        m_len[2] = 2; m_code[2] = 1;
        m_len[4] = 2; m_code[4] = 2;
        m_len[6] = 2; m_code[6] = 3;
        send(q, 1'b1);
        collect_check("even_gaps");

        // Two trailing sym7 samples land during the build and must vanish.
        q = {};
        for (int i = 0; i < NSAMP; i++) q.push_back(int'($urandom_range(0, 6)));
        model_from(q);
        q.push_back(7);
        q.push_back(7);
        send(q, 1'b0);
        collect_check("overrun");
        q2 = {};
        for (int i = 0; i < NSAMP; i++) q2.push_back(int'($urandom_range(0, 6)));
        model_from(q2);
        send(q2, 1'b1);
        collect_check("after_overrun");

        q = {};
        for (int i = 0; i < NSAMP; i++) q.push_back(int'($urandom_range(0, 7)));
        send(q, 1'b0);
        waited = 0;
        while (bus.data_out_state !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("abort_reached_output", int'(bus.data_out_state), 1);
        reset_n = 1'b0;
        #1;
        check("abort_outputs_zero",
              int'({bus.data_out_state, bus.data_out_symbol, bus.data_out_length, bus.data_out_code}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (bus.data_out_state !== 1'b0) stray = 1'b1;
        end
        check("abort_no_resume", int'(stray), 0);
        q = {};
        for (int i = 0; i < NSAMP; i++) q.push_back(int'($urandom_range(0, 7)));
        model_from(q);
        send(q, 1'b1);
        collect_check("post_abort");

        for (int b = 0; b < 25; b++) begin
            hi = int'($urandom_range(0, 7));
            q  = {};
            for (int i = 0; i < NSAMP; i++) q.push_back(int'($urandom_range(0, hi)));
            model_from(q);
            send(q, b[0]);
            collect_check("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
